// File: rtl/mem_stage_ctrl_pkg.sv
// Shared LC-3b types for the memory stage: words, opcodes, the decoded
// control word carried in EX/MEM, write lane masks and the MEM FSM states.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [3:0] {
    op_br   = 4'b0000,
    op_add  = 4'b0001,
    op_ldb  = 4'b0010,
    op_stb  = 4'b0011,
    op_jsr  = 4'b0100,
    op_and  = 4'b0101,
    op_ldr  = 4'b0110,
    op_str  = 4'b0111,
    op_rti  = 4'b1000,
    op_not  = 4'b1001,
    op_ldi  = 4'b1010,
    op_sti  = 4'b1011,
    op_jmp  = 4'b1100,
    op_shf  = 4'b1101,
    op_lea  = 4'b1110,
    op_trap = 4'b1111
  } lc3b_opcode;

  typedef struct packed {
    lc3b_opcode opcode;
    logic       mem_read;
    logic       mem_write;
    logic       ldbmux_sel;
  } lc3b_control_word;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IND  = 2'd1,
    ACC  = 2'd2
  } mem_state_t;

  // LDI/STI fetch a pointer first, then access through it.
  function automatic logic is_indirect(lc3b_opcode op);
    return (op == op_ldi) || (op == op_sti);
  endfunction

  function automatic logic is_byte_op(lc3b_opcode op);
    return (op == op_ldb) || (op == op_stb);
  endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// Byte-lane steering for the data cache: write lane mask, replicated store
// data, and the zero-extended byte picked out of a load word.
module mem_byte_lane
  import lc3b_types::*;
(
  input  logic          addr0,
  input  logic          is_byte,
  input  lc3b_word      store_word,
  input  lc3b_word      read_word,
  output lc3b_mem_wmask byte_enable,
  output lc3b_word      wdata,
  output lc3b_word      rdata_byte
);

  always_comb begin
    byte_enable = 2'b11;
    wdata       = store_word;
    if (is_byte) begin
      byte_enable = addr0 ? 2'b10 : 2'b01;
      wdata       = {store_word[7:0], store_word[7:0]};
    end
  end

  assign rdata_byte = addr0 ? {8'h00, read_word[15:8]} : {8'h00, read_word[7:0]};

endmodule

// File: rtl/mem_stage_ctrl.sv
// LC-3b MEM stage controller: sequences word, byte, indirect and TRAP
// accesses to the data cache and stalls the pipeline until they finish.
module mem_stage_ctrl
  import lc3b_types::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid,
  input  lc3b_control_word    ctrl,
  input  logic [ADDR_W-1:0]   alu_out,
  input  logic [DATA_W-1:0]   store_data,
  input  logic                d_mem_resp,
  input  logic [DATA_W-1:0]   d_mem_rdata,
  output logic [ADDR_W-1:0]   d_mem_address,
  output logic                d_mem_read,
  output logic                d_mem_write,
  output logic [1:0]          d_mem_byte_enable,
  output logic [DATA_W-1:0]   d_mem_wdata,
  output logic                mem_stall,
  output logic                mem_done,
  output logic [DATA_W-1:0]   mem_rdata_out
);

  mem_state_t        state, state_next;
  lc3b_opcode        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [DATA_W-1:0] store_q;
  logic              ldb_q;
  logic              write_q;

  logic              memop;
  logic              ind_op;
  logic              byte_op;
  logic [ADDR_W-1:0] acc_base;
  lc3b_mem_wmask     lane_be;
  logic [DATA_W-1:0] lane_wdata;
  logic [DATA_W-1:0] lane_rdata;

  assign memop    = valid & (ctrl.mem_read | ctrl.mem_write);
  assign ind_op   = is_indirect(op_q);
  assign byte_op  = is_byte_op(op_q);
  assign acc_base = ind_op ? ptr_q : addr_q;

  mem_byte_lane u_lane (
    .addr0       (addr_q[0]),
    .is_byte     (byte_op),
    .store_word  (store_q),
    .read_word   (d_mem_rdata),
    .byte_enable (lane_be),
    .wdata       (lane_wdata),
    .rdata_byte  (lane_rdata)
  );

  // The EX/MEM instruction is captured once in IDLE so the request stays
  // stable while the pipeline is frozen around it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      op_q          <= op_br;
      addr_q        <= '0;
      ptr_q         <= '0;
      store_q       <= '0;
      ldb_q         <= 1'b0;
      write_q       <= 1'b0;
      mem_rdata_out <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && memop) begin
        op_q    <= ctrl.opcode;
        addr_q  <= alu_out;
        store_q <= store_data;
        ldb_q   <= ctrl.ldbmux_sel;
        write_q <= ctrl.mem_write;
      end
      if (state == IND && d_mem_resp)
        ptr_q <= d_mem_rdata[ADDR_W-1:0];
      if (state == ACC && d_mem_resp && !write_q)
        mem_rdata_out <= ldb_q ? lane_rdata : d_mem_rdata;
    end
  end

  always_comb begin
    state_next        = state;
    d_mem_address     = '0;
    d_mem_read        = 1'b0;
    d_mem_write       = 1'b0;
    d_mem_byte_enable = 2'b00;
    d_mem_wdata       = '0;
    mem_stall         = 1'b0;
    mem_done          = 1'b0;
    unique case (state)
      IDLE: begin
        mem_stall = memop;
        if (memop)
          state_next = is_indirect(ctrl.opcode) ? IND : ACC;
      end
      IND: begin
        d_mem_address     = {addr_q[ADDR_W-1:1], 1'b0};
        d_mem_read        = 1'b1;
        d_mem_byte_enable = 2'b11;
        mem_stall         = 1'b1;
        if (d_mem_resp)
          state_next = ACC;
      end
      ACC: begin
        // Only byte ops keep bit 0; word and pointer accesses are aligned.
        d_mem_address     = {acc_base[ADDR_W-1:1], byte_op & acc_base[0]};
        d_mem_read        = !write_q;
        d_mem_write       = write_q;
        d_mem_byte_enable = write_q ? lane_be : 2'b11;
        d_mem_wdata       = write_q ? lane_wdata : '0;
        mem_stall         = !d_mem_resp;
        if (d_mem_resp) begin
          mem_done   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Memory-stage controller for the 5-stage LC-3b pipeline.
- Consumes the decoded control word carried in the EX/MEM pipeline register: opcode, mem_read, mem_write, ldbmux_sel.
- Drives the data-cache request/response interface and stalls the pipeline until the access completes.
- Handles word and byte accesses, the two-access LDI/STI indirection, and the TRAP vector read; delivers aligned read data to writeback.

Parameters:
- ADDR_W, 16, address width
- DATA_W, 16, data width (must be 16; byte lanes are fixed at 2)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- valid  in  1  EX/MEM register holds a live instruction
- ctrl  in  lc3b_control_word  control word of the EX/MEM instruction
- alu_out  in  ADDR_W  effective address from EX
- store_data  in  DATA_W  SR value for ST/STB/STI
- d_mem_resp  in  1  cache access complete
- d_mem_rdata  in  DATA_W  cache read data, valid when resp=1
- d_mem_address  out  ADDR_W  request address
- d_mem_read  out  1  read request
- d_mem_write  out  1  write request
- d_mem_byte_enable  out  2  write lane mask
- d_mem_wdata  out  DATA_W  write data
- mem_stall  out  1  freeze IF/ID/EX and the EX/MEM register
- mem_done  out  1  one-cycle pulse on the access-completion cycle
- mem_rdata_out  out  DATA_W  registered load result for MEM/WB

Behaviour:
- Clock and reset:
  - Single clock clk. reset is synchronous and active-high.
  - Reset forces state IDLE and clears all latches; mem_rdata_out=0.
  - All outputs are 0 after the reset edge. A reset mid-access abandons it; the cache must tolerate a dropped request.
- Memory op: memop = valid & (ctrl.mem_read | ctrl.mem_write).
- States: IDLE, IND, ACC.
- IDLE:
  - No request is driven.
  - If memop, latch opcode, alu_out, store_data, ldbmux_sel and write.
  - Next state is IND for op_ldi/op_sti, otherwise ACC.
  - mem_stall = memop.
- IND:
  - Drives d_mem_read=1 at {addr_q[15:1],1'b0}.
  - Hold until d_mem_resp; then latch ptr_q = d_mem_rdata and go to ACC.
- ACC (final access):
  - Address: ptr_q for LDI/STI, else addr_q. Bit 0 is forced to 0 for word ops and kept for byte ops.
  - Drives d_mem_read = !write_q or d_mem_write = write_q.
  - Hold until d_mem_resp; then go to IDLE, assert mem_done=1 and mem_stall=0 in that same cycle.
  - On the same edge, capture the load result into mem_rdata_out.
- Stall: mem_stall=1 in IND, and in ACC while !d_mem_resp.
- Request stability: request signals, address and wdata stay stable from issue until resp.
- Write lanes and data:
  - Word write: byte_enable=2'b11, wdata=store_q.
  - Byte write (STB): byte_enable = addr_q[0] ? 2'b10 : 2'b01; wdata = {store_q[7:0], store_q[7:0]}.
  - During reads byte_enable=2'b11.
- Load data:
  - Word load: d_mem_rdata.
  - LDB: zero-extended byte selected by addr_q[0] (1 = [15:8]).
  - TRAP: word read at alu_out; the vector is formed upstream.
- Writes leave mem_rdata_out unchanged.
- Latency with a 1-cycle cache: 2 cycles for a plain access, 3 for LDI/STI. Each cache wait cycle adds 1.
- Boundary cases:
  - d_mem_resp in IDLE is ignored.
  - valid=0 or a non-memory op: no stall, no request, state stays IDLE.
  - Back-to-back memory ops always pass through IDLE, so the next request issues one cycle after mem_done.
  - Odd word address: bit 0 is silently cleared.
  - Odd LDI pointer: bit 0 is cleared on the second access.

Decomposition:
- lc3b_types package:
  - Add lc3b_mem_wmask (2-bit).
  - Add enum mem_state_t {IDLE, IND, ACC}.
  - Reuse lc3b_word, lc3b_opcode and lc3b_control_word.
- Sub-module mem_byte_lane (combinational): takes addr bit 0, a byte flag, store data and read data; produces byte_enable, replicated wdata and extracted load data.
- The FSM and latches live in mem_stage_ctrl.

Test Plan:
- LDR: alu_out=0x3005, mem_read, cache resp after 2 waits with rdata=0xBEEF -> d_mem_address=0x3004, d_mem_read held 3 cycles in ACC, mem_stall high until the resp cycle, mem_done pulse, mem_rdata_out=0xBEEF.
- STB odd: alu_out=0x4001, store_data=0x12AB -> d_mem_write=1, byte_enable=2'b10, wdata=0xABAB, address=0x4001; even address 0x4000 -> byte_enable=2'b01.
- LDB: alu_out=0x5001, rdata=0x7F80 -> mem_rdata_out=0x007F; alu_out=0x5000 -> 0x0080.
- LDI: alu_out=0x6000, first resp rdata=0x7003, second resp rdata=0x1234 -> first read at 0x6000, second read at 0x7002, mem_rdata_out=0x1234, total 3 cycles with an immediate cache.
- STI: pointer read returns 0x8000, store_data=0x5555 -> read at alu_out, then write at 0x8000 with byte_enable=2'b11, single mem_done pulse.
- Reset asserted in IND while d_mem_read=1 -> next cycle state IDLE, d_mem_read=0, mem_stall=0, mem_rdata_out=0; a stray d_mem_resp afterwards is ignored.
